// File: rtl/cnt_seq_ctrl_pkg.sv
// Shared types and defaults for the counter sequencer.
package cnt_seq_ctrl_pkg;

  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_CW        = 32;

  typedef logic [DEF_CW-1:0] thr_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    RUN,
    NEXT,
    SKIP,
    DONE
  } seq_state_e;

endpackage

// File: rtl/cnt_seq_ctrl_if.sv
// Bundle of table-config, sequence-control, counter and status signals of the sequencer.
interface cnt_seq_ctrl_if
  import cnt_seq_ctrl_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int CW        = DEF_CW
);
  localparam int IW = $clog2(NUM_SLOTS);
  localparam int LW = $clog2(NUM_SLOTS + 1);

  logic          cfg_we_i;
  logic [IW-1:0] cfg_idx_i;
  logic [CW-1:0] cfg_thr_i;
  logic [LW-1:0] seq_len_i;
  logic          loop_i;
  logic          start_i;
  logic          stop_i;
  logic [CW-1:0] cnt_val_i;
  logic          cnt_tc_i;
  logic          cnt_en_o;
  logic          cnt_clr_o;
  logic [CW-1:0] cnt_thr_o;
  logic          busy_o;
  logic [IW-1:0] slot_o;
  logic          slot_done_o;
  logic          seq_done_o;
  logic [CW-1:0] remain_o;

  modport master (
    output cfg_we_i, cfg_idx_i, cfg_thr_i, seq_len_i, loop_i, start_i, stop_i,
           cnt_val_i, cnt_tc_i,
    input  cnt_en_o, cnt_clr_o, cnt_thr_o, busy_o, slot_o, slot_done_o,
           seq_done_o, remain_o
  );

  modport slave (
    input  cfg_we_i, cfg_idx_i, cfg_thr_i, seq_len_i, loop_i, start_i, stop_i,
           cnt_val_i, cnt_tc_i,
    output cnt_en_o, cnt_clr_o, cnt_thr_o, busy_o, slot_o, slot_done_o,
           seq_done_o, remain_o
  );

endinterface

// File: rtl/cnt_seq_table.sv
// Threshold table: NUM_SLOTS x CW registers, synchronous write, asynchronous read.
module cnt_seq_table
  import cnt_seq_ctrl_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int CW        = DEF_CW,
  localparam int IW       = $clog2(NUM_SLOTS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [CW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [CW-1:0] rdata
);

  logic [CW-1:0] mem [NUM_SLOTS];

  // Write port; reset clears every slot so an unprogrammed slot is skipped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_SLOTS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Counter sequencer: runs threshold slots back-to-back, driving counter enable/clear/threshold.
//
// state | meaning
// IDLE  | waiting for start; counter not driven
// LOAD  | clear counter, capture table[slot] into the threshold register
// ARM   | one settle cycle after clear before enabling the counter
// RUN   | counter enabled, waiting for terminal count
// NEXT  | slot finished (slot_done pulse), pick next slot or finish
// SKIP  | slot threshold was 0, advance without a pulse
// DONE  | non-looping sequence finished (seq_done pulse)
module cnt_seq_ctrl
  import cnt_seq_ctrl_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int CW        = DEF_CW
) (
  input logic          clk_i,
  input logic          rst_i,
  cnt_seq_ctrl_if.slave bus
);

  localparam int IW = $clog2(NUM_SLOTS);
  localparam int LW = $clog2(NUM_SLOTS + 1);

  seq_state_e    state_q, state_nxt;
  logic [IW-1:0] slot_q, slot_nxt;
  logic [LW-1:0] len_q;
  logic          loop_q;
  logic [CW-1:0] thr_q;
  logic [CW-1:0] tbl_rd;
  logic          last_slot;
  logic          en_q, clr_q, busy_q, slot_done_q, seq_done_q;

  cnt_seq_table #(
    .NUM_SLOTS(NUM_SLOTS),
    .CW       (CW)
  ) u_table (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (bus.cfg_we_i),
    .waddr (bus.cfg_idx_i),
    .wdata (bus.cfg_thr_i),
    .raddr (slot_q),
    .rdata (tbl_rd)
  );

  // Index wraps on the latched length, not on the table size.
  assign last_slot = (LW'(slot_q) == (len_q - LW'(1)));

  // Next-state and next-slot selection; stop overrides everything outside IDLE.
  always_comb begin
    state_nxt = state_q;
    slot_nxt  = slot_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          slot_nxt  = '0;
          state_nxt = (bus.seq_len_i != '0) ? LOAD : DONE;
        end
      end
      LOAD: state_nxt = (tbl_rd == '0) ? SKIP : ARM;
      ARM:  state_nxt = RUN;
      RUN:  if (bus.cnt_tc_i) state_nxt = NEXT;
      NEXT, SKIP: begin
        if (last_slot) begin
          if (loop_q) begin
            state_nxt = LOAD;
            slot_nxt  = '0;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          state_nxt = LOAD;
          slot_nxt  = slot_q + IW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.stop_i && (state_q != IDLE)) begin
      state_nxt = IDLE;
      slot_nxt  = slot_q;
    end
  end

  // State, latched sequence config, threshold register and outputs registered from next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      len_q       <= '0;
      loop_q      <= 1'b0;
      thr_q       <= '0;
      en_q        <= 1'b0;
      clr_q       <= 1'b0;
      busy_q      <= 1'b0;
      slot_done_q <= 1'b0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      slot_q  <= slot_nxt;
      if ((state_q == IDLE) && bus.start_i) begin
        len_q  <= bus.seq_len_i;
        loop_q <= bus.loop_i;
      end
      if (state_q == LOAD) thr_q <= tbl_rd;
      en_q        <= (state_nxt == RUN);
      clr_q       <= (state_nxt == LOAD);
      busy_q      <= (state_nxt == LOAD) || (state_nxt == ARM) || (state_nxt == RUN) ||
                     (state_nxt == NEXT) || (state_nxt == SKIP);
      slot_done_q <= (state_nxt == NEXT);
      seq_done_q  <= (state_nxt == DONE);
    end
  end

  assign bus.cnt_en_o    = en_q;
  assign bus.cnt_clr_o   = clr_q;
  assign bus.cnt_thr_o   = thr_q;
  assign bus.busy_o      = busy_q;
  assign bus.slot_o      = slot_q;
  assign bus.slot_done_o = slot_done_q;
  assign bus.seq_done_o  = seq_done_q;
  // Saturating distance to threshold, only meaningful while the counter runs.
  assign bus.remain_o    = ((state_q == RUN) && (thr_q > bus.cnt_val_i)) ? (thr_q - bus.cnt_val_i) : '0;

endmodule
